// File: rtl/axi_write_only_ctrl_pkg.sv
// Shared types and helpers for the AXI write-only SRAM bridge.
package axi_write_only_ctrl_pkg;

    typedef enum logic [1:0] {IDLE, DATA, RESP} state_t;

    localparam logic [1:0] BRESP_OKAY = 2'b00;

    function automatic int log2(input int n);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++)
            if ((1 << i) < n) r = i + 1;
        return r;
    endfunction

endpackage

// File: rtl/axi_write_only_ctrl.sv
// AXI4 write-only slave: one AW+W burst at a time into granted single-port SRAM
// write cycles, then a single OKAY B response.
module axi_write_only_ctrl
    import axi_write_only_ctrl_pkg::*;
#(
    parameter int AXI4_ADDRESS_WIDTH = 32,
    parameter int AXI4_RDATA_WIDTH   = 64,
    parameter int AXI4_WDATA_WIDTH   = 64,
    parameter int AXI4_ID_WIDTH      = 16,
    parameter int AXI4_USER_WIDTH    = 10,
    parameter int AXI_NUMBYTES       = AXI4_WDATA_WIDTH / 8,
    parameter int MEM_ADDR_WIDTH     = 16
) (
    input  logic                          clk,
    input  logic                          rst_n,

    input  logic [AXI4_ID_WIDTH-1:0]      AWID_i,
    input  logic [AXI4_ADDRESS_WIDTH-1:0] AWADDR_i,
    input  logic [7:0]                    AWLEN_i,
    input  logic [2:0]                    AWSIZE_i,
    input  logic [1:0]                    AWBURST_i,
    input  logic                          AWLOCK_i,
    input  logic [3:0]                    AWCACHE_i,
    input  logic [2:0]                    AWPROT_i,
    input  logic [3:0]                    AWREGION_i,
    input  logic [3:0]                    AWQOS_i,
    input  logic [AXI4_USER_WIDTH-1:0]    AWUSER_i,
    input  logic                          AWVALID_i,
    output logic                          AWREADY_o,

    input  logic [AXI4_WDATA_WIDTH-1:0]   WDATA_i,
    input  logic [AXI_NUMBYTES-1:0]       WSTRB_i,
    input  logic                          WLAST_i,
    input  logic [AXI4_USER_WIDTH-1:0]    WUSER_i,
    input  logic                          WVALID_i,
    output logic                          WREADY_o,

    output logic [AXI4_ID_WIDTH-1:0]      BID_o,
    output logic [1:0]                    BRESP_o,
    output logic [AXI4_USER_WIDTH-1:0]    BUSER_o,
    output logic                          BVALID_o,
    input  logic                          BREADY_i,

    output logic                          MEM_CEN_o,
    output logic                          MEM_WEN_o,
    output logic [MEM_ADDR_WIDTH-1:0]     MEM_A_o,
    output logic [AXI4_RDATA_WIDTH-1:0]   MEM_D_o,
    output logic [AXI_NUMBYTES-1:0]       MEM_BE_o,
    input  logic [AXI4_RDATA_WIDTH-1:0]   MEM_Q_i,

    input  logic                          grant_i,
    output logic                          valid_o
);

    localparam int OFFS = log2(AXI_NUMBYTES);

    state_t                      state, state_n;
    logic [AXI4_ID_WIDTH-1:0]    id_q;
    logic [AXI4_USER_WIDTH-1:0]  user_q;
    logic [7:0]                  len_q, beat_q;
    logic [MEM_ADDR_WIDTH-1:0]   addr_q;
    logic                        aw_hs, w_hs;

    // Burst type/size, WLAST, WUSER and the read port play no part in a write.
    logic unused_inputs;
    assign unused_inputs = ^{AWSIZE_i, AWBURST_i, AWLOCK_i, AWCACHE_i, AWPROT_i,
                             AWREGION_i, AWQOS_i, AWADDR_i, WLAST_i, WUSER_i, MEM_Q_i};

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state  <= IDLE;
            id_q   <= '0;
            user_q <= '0;
            len_q  <= '0;
            beat_q <= '0;
            addr_q <= '0;
        end else begin
            state <= state_n;
            if (aw_hs) begin
                id_q   <= AWID_i;
                user_q <= AWUSER_i;
                len_q  <= AWLEN_i;
                beat_q <= '0;
                addr_q <= AWADDR_i[MEM_ADDR_WIDTH+OFFS-1:OFFS];
            end else if (w_hs) begin
                addr_q <= addr_q + 1'b1;
                beat_q <= beat_q + 8'd1;
            end
        end
    end

    // Outputs are gated by rst_n so they are quiet for the whole reset cycle,
    // not just after the first edge.
    always_comb begin
        state_n   = state;
        aw_hs     = 1'b0;
        w_hs      = 1'b0;
        AWREADY_o = 1'b0;
        WREADY_o  = 1'b0;
        BVALID_o  = 1'b0;
        BID_o     = '0;
        BUSER_o   = '0;
        BRESP_o   = BRESP_OKAY;
        valid_o   = 1'b0;
        MEM_CEN_o = 1'b1;
        MEM_WEN_o = 1'b1;
        MEM_A_o   = addr_q;
        MEM_D_o   = '0;
        MEM_BE_o  = '0;
        if (rst_n) begin
            case (state)
                IDLE: begin
                    AWREADY_o = 1'b1;
                    aw_hs     = AWVALID_i;
                    if (aw_hs) state_n = DATA;
                end
                DATA: begin
                    valid_o   = WVALID_i;
                    WREADY_o  = grant_i;
                    MEM_CEN_o = ~WVALID_i;
                    MEM_WEN_o = ~WVALID_i;
                    MEM_D_o   = WDATA_i;
                    MEM_BE_o  = WSTRB_i;
                    w_hs      = WVALID_i & grant_i;
                    // Burst length comes from AWLEN alone; WLAST is not trusted.
                    if (w_hs && beat_q == len_q) state_n = RESP;
                end
                RESP: begin
                    BVALID_o = 1'b1;
                    BID_o    = id_q;
                    BUSER_o  = user_q;
                    if (BREADY_i) state_n = IDLE;
                end
                default: state_n = IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_axi_write_only_ctrl.sv
// Self-checking bench: table-driven bursts, randomized bursts against a queue model,
// and hand sequences for early W data and reset mid-burst.
module tb_axi_write_only_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] AWID_i;
    logic [31:0] AWADDR_i;
    logic [7:0]  AWLEN_i;
    logic [2:0]  AWSIZE_i;
    logic [1:0]  AWBURST_i;
    logic        AWLOCK_i;
    logic [3:0]  AWCACHE_i;
    logic [2:0]  AWPROT_i;
    logic [3:0]  AWREGION_i;
    logic [3:0]  AWQOS_i;
    logic [9:0]  AWUSER_i;
    logic        AWVALID_i, AWREADY_o;
    logic [63:0] WDATA_i;
    logic [7:0]  WSTRB_i;
    logic        WLAST_i;
    logic [9:0]  WUSER_i;
    logic        WVALID_i, WREADY_o;
    logic [15:0] BID_o;
    logic [1:0]  BRESP_o;
    logic [9:0]  BUSER_o;
    logic        BVALID_o, BREADY_i;
    logic        MEM_CEN_o, MEM_WEN_o;
    logic [15:0] MEM_A_o;
    logic [63:0] MEM_D_o;
    logic [7:0]  MEM_BE_o;
    logic [63:0] MEM_Q_i;
    logic        grant_i, valid_o;

    axi_write_only_ctrl dut (
        .clk(clk), .rst_n(rst_n),
        .AWID_i(AWID_i), .AWADDR_i(AWADDR_i), .AWLEN_i(AWLEN_i), .AWSIZE_i(AWSIZE_i),
        .AWBURST_i(AWBURST_i), .AWLOCK_i(AWLOCK_i), .AWCACHE_i(AWCACHE_i), .AWPROT_i(AWPROT_i),
        .AWREGION_i(AWREGION_i), .AWQOS_i(AWQOS_i), .AWUSER_i(AWUSER_i),
        .AWVALID_i(AWVALID_i), .AWREADY_o(AWREADY_o),
        .WDATA_i(WDATA_i), .WSTRB_i(WSTRB_i), .WLAST_i(WLAST_i), .WUSER_i(WUSER_i),
        .WVALID_i(WVALID_i), .WREADY_o(WREADY_o),
        .BID_o(BID_o), .BRESP_o(BRESP_o), .BUSER_o(BUSER_o), .BVALID_o(BVALID_o), .BREADY_i(BREADY_i),
        .MEM_CEN_o(MEM_CEN_o), .MEM_WEN_o(MEM_WEN_o), .MEM_A_o(MEM_A_o), .MEM_D_o(MEM_D_o),
        .MEM_BE_o(MEM_BE_o), .MEM_Q_i(MEM_Q_i), .grant_i(grant_i), .valid_o(valid_o)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    logic [87:0] wlog[$];   // {addr, data, be} of every committed write
    logic [87:0] exp_q[$];

    // A write is committed in any cycle with chip+write enable low and grant high.
    always @(negedge clk)
        if (!MEM_CEN_o && !MEM_WEN_o && grant_i)
            wlog.push_back({MEM_A_o, MEM_D_o, MEM_BE_o});

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        AWVALID_i = 0; WVALID_i = 0; grant_i = 0; BREADY_i = 0; WLAST_i = 0;
        WDATA_i = '0; WSTRB_i = '0;
    endtask

    task automatic compare_log();
        chk("nwrites", 128'(wlog.size()), 128'(exp_q.size()));
        for (int i = 0; i < wlog.size() && i < exp_q.size(); i++)
            chk("write", wlog[i], exp_q[i]);
    endtask

    // One complete burst; expectations come from the AXI rules: word i lands at a0+i mod 2^16.
    task automatic run_burst(input logic [31:0] a, input int len, input logic [15:0] id,
                             input logic [9:0] usr, input bit rg, input int bdly,
                             input logic [15:0] a0, input int nbeats);
        logic [63:0] d;
        logic [7:0]  s;
        logic [15:0] ea;
        bit g, wv, done;
        int cyc;
        tick();
        wlog.delete(); exp_q.delete();
        idle_inputs();
        AWVALID_i = 1; AWADDR_i = a; AWLEN_i = 8'(len); AWID_i = id; AWUSER_i = usr;
        #3;
        chk("awready_idle", AWREADY_o, 1);
        chk("wready_idle", WREADY_o, 0);
        for (int i = 0; i < nbeats; i++) begin
            d  = {$urandom, $urandom};
            s  = rg ? 8'($urandom) : 8'hFF;
            ea = a0 + 16'(i);
            exp_q.push_back({ea, d, s});
            done = 0; cyc = 0;
            while (!done) begin
                tick();
                AWVALID_i = 0;
                g  = rg ? 1'($urandom) : 1'b1;
                wv = rg ? ($urandom_range(0, 3) != 0) : 1'b1;
                WVALID_i = wv; WDATA_i = d; WSTRB_i = s; WLAST_i = (i == nbeats - 1); grant_i = g;
                #3;
                chk("awready_data", AWREADY_o, 0);
                chk("wready", WREADY_o, g);
                chk("valid", valid_o, wv);
                chk("cen", MEM_CEN_o, !wv);
                chk("wen", MEM_WEN_o, !wv);
                chk("mem_a", MEM_A_o, ea);
                chk("bvalid_data", BVALID_o, 0);
                done = g && wv;
                cyc++;
                if (!done && cyc >= 64) begin
                    chk("beat_timeout", 0, 1);
                    done = 1;
                end
            end
        end
        for (int k = 0; k <= bdly; k++) begin
            tick();
            idle_inputs();
            BREADY_i = (k == bdly);
            #3;
            chk("bvalid", BVALID_o, 1);
            chk("bid", BID_o, id);
            chk("buser", BUSER_o, usr);
            chk("bresp", BRESP_o, 2'b00);
            chk("awready_resp", AWREADY_o, 0);
            chk("cen_resp", MEM_CEN_o, 1);
        end
        tick();
        idle_inputs();
        #3;
        chk("bvalid_done", BVALID_o, 0);
        chk("awready_back", AWREADY_o, 1);
        chk("mem_d_idle", MEM_D_o, 0);
        compare_log();
    endtask

    typedef struct {
        logic [31:0] addr;
        int          len;
        logic [15:0] id;
        logic [9:0]  user;
        bit          rnd_grant;
        int          bdly;
        logic [15:0] exp_a0;
        int          exp_beats;
    } vec_t;

    vec_t vt[5];

    initial begin
        vt[0] = '{32'h0000_1238, 0, 16'd5,    10'h03A, 1'b0, 0, 16'h0247, 1};
        vt[1] = '{32'h0000_0100, 7, 16'd9,    10'h011, 1'b0, 0, 16'h0020, 8};
        vt[2] = '{32'h0000_0040, 3, 16'h0077, 10'h002, 1'b1, 0, 16'h0008, 4};
        vt[3] = '{32'h0007_FFF8, 1, 16'd3,    10'h1FF, 1'b0, 0, 16'hFFFF, 2};
        vt[4] = '{32'h0000_8000, 2, 16'hABCD, 10'h005, 1'b0, 5, 16'h1000, 3};

        rst_n = 0;
        AWID_i = 0; AWADDR_i = 0; AWLEN_i = 0; AWSIZE_i = 3'd3; AWBURST_i = 2'd1; AWLOCK_i = 0;
        AWCACHE_i = 0; AWPROT_i = 0; AWREGION_i = 0; AWQOS_i = 0; AWUSER_i = 0; WUSER_i = 0;
        MEM_Q_i = '0;
        idle_inputs();
        tick(); tick();
        #3;
        chk("rst_awready", AWREADY_o, 0);
        chk("rst_wready", WREADY_o, 0);
        chk("rst_bvalid", BVALID_o, 0);
        chk("rst_valid", valid_o, 0);
        chk("rst_cen", MEM_CEN_o, 1);
        chk("rst_wen", MEM_WEN_o, 1);
        chk("rst_bid", BID_o, 0);
        tick();
        rst_n = 1;

        foreach (vt[i])
            run_burst(vt[i].addr, vt[i].len, vt[i].id, vt[i].user, vt[i].rnd_grant,
                      vt[i].bdly, vt[i].exp_a0, vt[i].exp_beats);

        // W data offered while idle must be held off until after the AW handshake.
        wlog.delete();
        for (int k = 0; k < 3; k++) begin
            tick();
            idle_inputs();
            WVALID_i = 1; WDATA_i = 64'hDEAD_BEEF_0000_0001; WSTRB_i = 8'hFF; grant_i = 1;
            #3;
            chk("early_wready", WREADY_o, 0);
            chk("early_cen", MEM_CEN_o, 1);
            chk("early_valid", valid_o, 0);
        end
        tick();
        idle_inputs();
        #3;
        chk("early_nwrites", 128'(wlog.size()), 0);
        run_burst(32'h0000_0200, 1, 16'h0042, 10'h0AA, 1'b0, 0, 16'h0040, 2);

        // Randomized bursts against the address/data model.
        for (int r = 0; r < 15; r++) begin
            logic [31:0] a;
            int ln;
            a  = $urandom;
            ln = $urandom_range(0, 7);
            run_burst(a, ln, 16'($urandom), 10'($urandom), 1'b1, $urandom_range(0, 3),
                      a[18:3], ln + 1);
        end

        // Reset mid-burst: two beats land, the rest and the B response are dropped.
        tick();
        wlog.delete();
        idle_inputs();
        AWVALID_i = 1; AWADDR_i = 32'h0000_0400; AWLEN_i = 8'd3; AWID_i = 16'd7; AWUSER_i = 10'd1;
        for (int k = 0; k < 2; k++) begin
            tick();
            idle_inputs();
            WVALID_i = 1; WDATA_i = 64'(k); WSTRB_i = 8'hFF; grant_i = 1;
        end
        tick();
        rst_n = 0;
        #3;
        chk("mid_rst_cen", MEM_CEN_o, 1);
        chk("mid_rst_wready", WREADY_o, 0);
        chk("mid_rst_valid", valid_o, 0);
        chk("mid_rst_awready", AWREADY_o, 0);
        for (int k = 0; k < 3; k++) begin
            tick();
            rst_n = 1;
            idle_inputs();
            #3;
            chk("post_rst_awready", AWREADY_o, 1);
            chk("post_rst_bvalid", BVALID_o, 0);
        end
        chk("mid_rst_nwrites", 128'(wlog.size()), 2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
